// File: rtl/uart_tx_serializer_pkg.sv
// ============================================================================
// Module  : uart_tx_serializer_pkg
// Purpose : Shared definitions for the UART TX serializer. This package holds
//           the default IO window address bits, the status word bit
//           positions and the transmit FSM state encoding.
// Ports   : none (package)
// Config  : the IO_MEM_MAP_BIT and UART_MEM_MAP_BIT macros may be predefined
//           to relocate the IO window. Otherwise the defaults below apply.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef IO_MEM_MAP_BIT
`define IO_MEM_MAP_BIT 22
`endif
`ifndef UART_MEM_MAP_BIT
`define UART_MEM_MAP_BIT 3
`endif

package uart_tx_serializer_pkg;

    // Bit positions inside the status word returned on reads of the window
    localparam int UART_ST_BUSY_BIT  = 0;
    localparam int UART_ST_FULL_BIT  = 1;
    localparam int UART_ST_EMPTY_BIT = 2;
    localparam int UART_ST_OVF_BIT   = 3;
    localparam int UART_ST_CNT_LSB   = 8;
    localparam int UART_ST_CNT_W     = 4;

    typedef enum logic [1:0] {
        UART_TX_IDLE  = 2'd0,
        UART_TX_START = 2'd1,
        UART_TX_DATA  = 2'd2,
        UART_TX_STOP  = 2'd3
    } uart_tx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_tx_serializer_if.sv
// ============================================================================
// Module  : uart_tx_serializer_if
// Purpose : CPU memory bus slice seen by the UART TX serializer.
// Ports   : mem_addr  - byte address
//           mem_rstrb - read strobe
//           mem_rdata - registered status word
//           mem_wmask - byte write mask
//           mem_wdata - write data
//           master    - CPU side; slave - serializer side
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_serializer_if;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;

    modport master (output mem_addr, mem_rstrb, mem_wmask, mem_wdata, input mem_rdata);
    modport slave  (input mem_addr, mem_rstrb, mem_wmask, mem_wdata, output mem_rdata);
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module  : uart_tx_fifo
// Purpose : Byte buffer for the UART transmitter.
//           - DEPTH > 1: circular buffer with wrap-bit pointers.
//           - DEPTH == 1: single holding register.
//           The caller only pushes when the buffer is not full or a pop
//           happens in the same cycle. Data is read combinationally at the
//           read pointer.
// Ports   : clk, rst (sync active-high)
//           push_i / wdata_i   - write one entry
//           pop_i  / rdata_o   - consume the head entry
//           full_o, empty_o    - pointer-derived flags
//           count_o            - occupancy
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] wdata_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic      [CNT_W-1:0] count_o
);

    generate
        if (DEPTH > 1) begin : g_fifo
            localparam int AW = $clog2(DEPTH);

            logic [WIDTH-1:0] mem_q [DEPTH];
            logic [AW:0]      wr_ptr_q, wr_ptr_d;
            logic [AW:0]      rd_ptr_q, rd_ptr_d;

            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
                if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                end
            end

            // Storage needs no reset because the pointers define validity
            always_ff @(posedge clk) begin
                if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
            end

            // Equal indices mean full or empty. The wrap bit tells them apart.
            assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
            assign empty_o = (wr_ptr_q == rd_ptr_q);
            assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                             (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
            assign count_o = CNT_W'(wr_ptr_q - rd_ptr_q);
        end else begin : g_hold
            logic [WIDTH-1:0] data_q, data_d;
            logic             valid_q, valid_d;

            always_comb begin
                data_d  = data_q;
                valid_d = valid_q;
                if (pop_i)  valid_d = 1'b0;
                // A push in the same cycle as a pop refills the slot
                if (push_i) begin
                    data_d  = wdata_i;
                    valid_d = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    data_q  <= data_d;
                    valid_q <= valid_d;
                end
            end

            assign rdata_o = data_q;
            assign empty_o = ~valid_q;
            assign full_o  = valid_q;
            assign count_o = CNT_W'(valid_q);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
// ============================================================================
// Module  : uart_tx_serializer
// Purpose : Accepts CPU byte writes to the UART IO window and buffers them.
//           It sends each byte on tx_o as an 8N1 frame and returns a status
//           word on reads of the same window.
// Ports   : clk, rst       - clock, synchronous active-high reset
//           mem (slave)    - addr/rstrb/rdata/wmask/wdata bus slice
//           tx_o           - serial line, idles high, driven from a flop
// Config  : UART_TX_FIFO_EN defined  -> FIFO of FIFO_DEPTH entries
//           UART_TX_FIFO_EN undefined -> single holding register
// Status  : [0] busy [1] full [2] empty [3] overflow [11:8] occupancy
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int IO_MEM_MAP_BIT   = `IO_MEM_MAP_BIT,
    parameter int UART_MEM_MAP_BIT = `UART_MEM_MAP_BIT,
    parameter int CLKS_PER_BIT     = 868,
    parameter int FIFO_DEPTH       = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    uart_tx_serializer_if.slave  mem,
    output logic                 tx_o
);

`ifdef UART_TX_FIFO_EN
    localparam int C_BUF_DEPTH = FIFO_DEPTH;
`else
    // FIFO_DEPTH has no effect in the single-register build
    localparam int C_BUF_DEPTH = (FIFO_DEPTH > 0) ? 1 : 1;
`endif
    localparam int C_CNT_W = $clog2(CLKS_PER_BIT);

    // ---------------- decode ----------------
    logic w_sel, w_rd, w_push_req, w_push, w_pop;
    logic w_full, w_empty;
    logic [7:0] w_head;
    logic [UART_ST_CNT_W-1:0] w_count;
    logic w_unused_bits;

    assign w_sel      = mem.mem_addr[IO_MEM_MAP_BIT] & mem.mem_addr[UART_MEM_MAP_BIT];
    assign w_rd       = w_sel & mem.mem_rstrb;
    assign w_push_req = w_sel & mem.mem_wmask[0];
    // A full buffer still takes a byte when the FSM pops in the same cycle
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_unused_bits = ^{mem.mem_addr, mem.mem_wmask[3:1], mem.mem_wdata[31:8]};

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (C_BUF_DEPTH),
        .CNT_W (UART_ST_CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .wdata_i (mem.mem_wdata[7:0]),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    // ---------------- state ----------------
    uart_tx_state_e       state_q, state_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 ovf_q, ovf_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [31:0]          w_status;
    logic                 w_bit_end;

    assign w_bit_end = (cnt_q == C_CNT_W'(CLKS_PER_BIT - 1));

    // tx_d holds the line level for the next cycle. tx_o is a flop and
    // therefore free of glitches.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        w_pop   = 1'b0;
        case (state_q)
            UART_TX_IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    shift_d = w_head;
                    state_d = UART_TX_START;
                    tx_d    = 1'b0;
                end
            end
            UART_TX_START: begin
                if (w_bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = UART_TX_DATA;
                    tx_d    = shift_q[0];
                end
            end
            UART_TX_DATA: begin
                if (w_bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = UART_TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end
            end
            UART_TX_STOP: begin
                if (w_bit_end) begin
                    cnt_d = '0;
                    if (!w_empty) begin
                        // Chain straight into the next frame, with no idle gap
                        w_pop   = 1'b1;
                        shift_d = w_head;
                        state_d = UART_TX_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = UART_TX_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = UART_TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // ---------------- status / overflow ----------------
    always_comb begin
        w_status = '0;
        w_status[UART_ST_BUSY_BIT]  = (state_q != UART_TX_IDLE);
        w_status[UART_ST_FULL_BIT]  = w_full;
        w_status[UART_ST_EMPTY_BIT] = w_empty;
        w_status[UART_ST_OVF_BIT]   = ovf_q;
        w_status[UART_ST_CNT_LSB +: UART_ST_CNT_W] = w_count;

        rdata_d = rdata_q;
        if (w_rd) rdata_d = w_status;

        // If a drop happens in the same cycle as a read, the drop wins.
        // This keeps the new overflow visible to the next read.
        ovf_d = ovf_q;
        if (w_rd) ovf_d = 1'b0;
        if (w_push_req && !w_push) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UART_TX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
        end
    end

    assign tx_o          = tx_q;
    assign mem.mem_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
// ============================================================================
// Module  : tb_uart_tx_serializer
// Purpose : Directed self-checking bench for uart_tx_serializer with
//           CLKS_PER_BIT=4. A background decoder collects every complete
//           frame seen on tx_o, together with the cycle of its start bit.
//           Tests for the FIFO build run when UART_TX_FIFO_EN is defined.
//           The single-register test runs otherwise.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_serializer;

    localparam int CLKS_PER_BIT = 4;
    localparam logic [31:0] UART_ADDR  = 32'h0040_0008;
    localparam logic [31:0] OTHER_ADDR = 32'h0000_0008;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_o;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    uart_tx_serializer_if bus();

    uart_tx_serializer #(
        .IO_MEM_MAP_BIT   (22),
        .UART_MEM_MAP_BIT (3),
        .CLKS_PER_BIT     (CLKS_PER_BIT),
        .FIFO_DEPTH       (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .mem  (bus),
        .tx_o (tx_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- background frame decoder ----------------
    logic [9:0] rx_frames[$];
    int         rx_starts[$];
    int         rx_glitches = 0;

    initial begin : p_decoder
        logic [9:0] frame;
        int         start;
        bit         aborted;
        forever begin
            @(posedge clk); #2;
            if (rst !== 1'b1 && tx_o === 1'b0) begin
                start   = cyc;
                frame   = '0;
                aborted = 1'b0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < CLKS_PER_BIT; c++) begin
                        if (!aborted) begin
                            if (b != 0 || c != 0) begin @(posedge clk); #2; end
                            if (rst === 1'b1)        aborted = 1'b1;
                            else if (c == 0)         frame[b] = tx_o;
                            else if (tx_o !== frame[b]) rx_glitches++;
                        end
                    end
                end
                if (!aborted) begin
                    rx_frames.push_back(frame);
                    rx_starts.push_back(start);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [3:0] m, input logic [7:0] d);
        bus.mem_addr  = a;
        bus.mem_wmask = m;
        bus.mem_wdata = {24'h0, d};
        step(1);
        bus.mem_addr  = '0;
        bus.mem_wmask = '0;
    endtask

    task automatic bus_rd(output logic [31:0] v);
        bus.mem_addr  = UART_ADDR;
        bus.mem_rstrb = 1'b1;
        step(1);
        bus.mem_rstrb = 1'b0;
        bus.mem_addr  = '0;
        v = bus.mem_rdata;
    endtask

    // Compares the next decoded frame against the 8N1 encoding of d
    task automatic check_frame(input string tag, input logic [7:0] d, input int exp_start);
        logic [9:0] f;
        int         s;
        f = 'x;
        s = -1;
        if (rx_frames.size() > 0) begin
            f = rx_frames.pop_front();
            s = rx_starts.pop_front();
        end
        check({tag, "_bits"}, {22'h0, f}, {22'h0, 1'b1, d, 1'b0});
        check({tag, "_start"}, 32'(s), 32'(exp_start));
    endtask

    task automatic rx_clear();
        rx_frames.delete();
        rx_starts.delete();
    endtask

    initial begin : p_watchdog
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : p_main
        logic [31:0] v;
        int          we;
        int          low;
        bus.mem_addr  = '0;
        bus.mem_rstrb = 1'b0;
        bus.mem_wmask = '0;
        bus.mem_wdata = '0;

        // Reset state
        rst = 1'b1;
        step(3);
        check("rst_tx", {31'h0, tx_o}, 32'h1);
        check("rst_rdata", bus.mem_rdata, 32'h0);
        rst = 1'b0;

        // 1: single byte 0x55
        bus_wr(UART_ADDR, 4'b0001, 8'h55);
        we = cyc;
        check("t1_tx_at_push", {31'h0, tx_o}, 32'h1);
        step(1);
        check("t1_tx_start_low", {31'h0, tx_o}, 32'h0);
        step(40);
        check("t1_tx_idle_high", {31'h0, tx_o}, 32'h1);
        bus_rd(v);
        check("t1_status", v, 32'h0000_0004);
        check("t1_nframes", 32'(rx_frames.size()), 32'd1);
        check_frame("t1_f0", 8'h55, we + 1);
        rx_clear();

`ifdef UART_TX_FIFO_EN
        // 2: three back-to-back frames
        bus_wr(UART_ADDR, 4'b0001, 8'h41);
        we = cyc;
        bus_wr(UART_ADDR, 4'b0001, 8'h42);
        bus_wr(UART_ADDR, 4'b0001, 8'h43);
        step(125);
        check("t2_nframes", 32'(rx_frames.size()), 32'd3);
        check_frame("t2_A", 8'h41, we + 1);
        check_frame("t2_B", 8'h42, we + 41);
        check_frame("t2_C", 8'h43, we + 81);
        bus_rd(v);
        check("t2_status", v, 32'h0000_0004);
        rx_clear();

        // 3: overflow on the 10th byte
        for (int i = 0; i < 10; i++) bus_wr(UART_ADDR, 4'b0001, 8'(8'h30 + i));
        bus_rd(v);
        check("t3_status_ovf", v, 32'h0000_080B);
        bus_rd(v);
        check("t3_status_ovf_clr", v, 32'h0000_0803);
        step(380);
        check("t3_nframes", 32'(rx_frames.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            logic [9:0] f;
            f = (rx_frames.size() > 0) ? rx_frames.pop_front() : 10'bx;
            check($sformatf("t3_f%0d", i), {22'h0, f}, {22'h0, 1'b1, 8'(8'h30 + i), 1'b0});
        end
        bus_rd(v);
        check("t3_status_end", v, 32'h0000_0004);
        rx_clear();
`else
        // 6: single holding register, so the third byte is dropped
        bus_wr(UART_ADDR, 4'b0001, 8'h41);
        we = cyc;
        bus_wr(UART_ADDR, 4'b0001, 8'h42);
        bus_wr(UART_ADDR, 4'b0001, 8'h43);
        bus_rd(v);
        check("t6_status_ovf", v, 32'h0000_010B);
        step(90);
        check("t6_nframes", 32'(rx_frames.size()), 32'd2);
        check_frame("t6_A", 8'h41, we + 1);
        check_frame("t6_B", 8'h42, we + 41);
        bus_rd(v);
        check("t6_status_end", v, 32'h0000_0004);
        rx_clear();
`endif

        // 4: reset during data bit 3 of a frame
        bus_wr(UART_ADDR, 4'b0001, 8'h00);
        step(18);
        check("t4_tx_before_rst", {31'h0, tx_o}, 32'h0);
        rst = 1'b1;
        step(1);
        check("t4_tx_after_rst", {31'h0, tx_o}, 32'h1);
        check("t4_rdata_after_rst", bus.mem_rdata, 32'h0);
        rst = 1'b0;
        bus_rd(v);
        check("t4_status", v, 32'h0000_0004);
        low = 0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (tx_o !== 1'b1) low++;
        end
        check("t4_line_quiet", 32'(low), 32'd0);
        check("t4_nframes", 32'(rx_frames.size()), 32'd0);
        rx_clear();

`ifdef UART_TX_FIFO_EN
        // 5: status while busy, ignored writes
        bus_wr(UART_ADDR, 4'b0001, 8'hFF);
        we = cyc;
        bus_wr(UART_ADDR, 4'b0001, 8'h11);
        bus_wr(UART_ADDR, 4'b0001, 8'h22);
        bus_rd(v);
        check("t5_status_busy", v, 32'h0000_0201);
        bus_wr(UART_ADDR, 4'b0010, 8'h33);
        bus_rd(v);
        check("t5_status_wmask", v, 32'h0000_0201);
        bus_wr(OTHER_ADDR, 4'b0001, 8'h44);
        bus_rd(v);
        check("t5_status_outside", v, 32'h0000_0201);
        step(140);
        check("t5_nframes", 32'(rx_frames.size()), 32'd3);
        check_frame("t5_f0", 8'hFF, we + 1);
        check_frame("t5_f1", 8'h11, we + 41);
        check_frame("t5_f2", 8'h22, we + 81);
        rx_clear();
`endif

        check("glitches", 32'(rx_glitches), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
